// File: rtl/jk_pkg.sv
// Shared JK command encoding for the jk_counter cells.
// A command is the {J,K} pair driven into one jk_ff cell for the next edge.
package jk_pkg;

  typedef logic [1:0] jk_cmd_t;

  localparam jk_cmd_t JK_HOLD = 2'b00;
  localparam jk_cmd_t JK_CLR  = 2'b01;
  localparam jk_cmd_t JK_SET  = 2'b10;
  localparam jk_cmd_t JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop storage cell with asynchronous active-low clear.
// Implements the standard JK truth table: hold, clear, set, toggle.
module jk_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_counter.sv
// Modulo-MODULUS counter whose storage is WIDTH jk_ff cells driven by per-bit JK commands.
// Down counting and the up port exist only when JK_COUNTER_DOWN_EN is defined.
module jk_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef JK_COUNTER_DOWN_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  jk_cmd_t          cmd [WIDTH];
  logic [WIDTH-1:0] eff_val;
  logic             wrap_next;
  logic             carry;
`ifdef JK_COUNTER_DOWN_EN
  logic             borrow;
`endif

  // Compare on WIDTH+1 bits so MODULUS == 2^WIDTH never saturates.
  assign eff_val = ({1'b0, load_val} < (WIDTH+1)'(MODULUS)) ? load_val : TOP;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) cmd[i] = JK_HOLD;
    wrap_next = 1'b0;
    carry     = 1'b1;
`ifdef JK_COUNTER_DOWN_EN
    borrow    = 1'b1;
`endif
    if (load) begin
      for (int i = 0; i < WIDTH; i++) cmd[i] = eff_val[i] ? JK_SET : JK_CLR;
    end else if (en) begin
`ifdef JK_COUNTER_DOWN_EN
      if (!up) begin
        if (q == '0) begin
          for (int i = 0; i < WIDTH; i++) cmd[i] = TOP[i] ? JK_SET : JK_CLR;
          wrap_next = 1'b1;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            cmd[i] = borrow ? JK_TOG : JK_HOLD;
            borrow = borrow & ~q[i];
          end
        end
      end else
`endif
      // Treating q >= TOP as terminal also recovers from unreachable out-of-range values.
      if (q >= TOP) begin
        for (int i = 0; i < WIDTH; i++) cmd[i] = JK_CLR;
        wrap_next = 1'b1;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          cmd[i] = carry ? JK_TOG : JK_HOLD;
          carry  = carry & q[i];
        end
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_ff u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (cmd[i][1]),
      .k     (cmd[i][0]),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap <= 1'b0;
    else        wrap <= wrap_next;
  end

`ifdef JK_COUNTER_DOWN_EN
  assign tc = en & (up ? (q == TOP) : (q == '0));
`else
  assign tc = en & (q == TOP);
`endif

endmodule
